// File: rtl/sort_data_server.sv
// Fitness store, population AND/OR, and ping-pong permutation banks serving the radix-sort sequencer.
// Optional build macro SORT_DESCENDING_EN inverts the queried gene bit so the final ranking is descending.
module sort_data_server #(
    parameter int         primaryInputCount = 8,
    parameter int         population        = 24,
    parameter logic [2:0] sort_controller   = 3'b001
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [2:0]                   state_controller,
    input  logic [3:0]                   state_sortFSM,
    input  logic [7:0]                   sortGeneCount,
    input  logic [7:0]                   sortBitCount,
    input  logic [7:0]                   sortedCounter,
    input  logic                         load_we,
    input  logic [7:0]                   load_index,
    input  logic [primaryInputCount+1:0] load_fitness,
    output logic                         gene,
    output logic [primaryInputCount+1:0] andAll,
    output logic [primaryInputCount+1:0] orAll,
    input  logic [7:0]                   rank_addr,
    output logic [7:0]                   rank_index,
    output logic                         sort_done,
    output logic                         load_err
);
    localparam int         W     = primaryInputCount + 2;
    localparam int         IDX_W = (population > 1) ? $clog2(population) : 1;
    localparam int         BIT_W = $clog2(W);
    localparam logic [7:0] POP8  = 8'(population);
    localparam logic [7:0] W8    = 8'(W);

    localparam logic [3:0] SFSM_INIT    = 4'd0;
    localparam logic [3:0] SFSM_ADVANCE = 4'd5;
    localparam logic [3:0] SFSM_PLACE0  = 4'd6;
    localparam logic [3:0] SFSM_PLACE1  = 4'd7;
    localparam logic [3:0] SFSM_DONE    = 4'd8;

    typedef logic [7:0] idx_t;

    logic [W-1:0] r_fitness [population];
    idx_t         r_bank    [2][population];
    logic         r_bank_sel;
    logic         r_dirty;
    logic         r_sort_done;
    logic         r_load_err;
    logic [W-1:0] r_and_all;
    logic [W-1:0] r_or_all;

    logic             w_sorting;
    logic             w_src_ok;
    logic             w_dst_ok;
    logic             w_gene_ok;
    logic             w_bit;
    logic [IDX_W-1:0] w_src_pos;
    logic [IDX_W-1:0] w_dst_pos;
    idx_t             w_src_gene;
    logic [W-1:0]     w_and;
    logic [W-1:0]     w_or;

    assign w_sorting = (state_controller == sort_controller);

    // Source bank is read combinationally: the sorter samples gene the cycle after moving its pointers.
    always_comb begin
        w_src_ok   = (sortGeneCount < POP8);
        w_dst_ok   = (sortedCounter < POP8);
        w_src_pos  = sortGeneCount[IDX_W-1:0];
        w_dst_pos  = sortedCounter[IDX_W-1:0];
        w_src_gene = w_src_ok ? r_bank[r_bank_sel][w_src_pos] : '0;
        w_gene_ok  = w_src_ok && (sortBitCount < W8) && (w_src_gene < POP8);
        w_bit      = 1'b0;
        if (w_gene_ok) begin
            w_bit = r_fitness[w_src_gene[IDX_W-1:0]][sortBitCount[BIT_W-1:0]];
        end
    end

`ifdef SORT_DESCENDING_EN
    assign gene = w_gene_ok & ~w_bit;
`else
    assign gene = w_gene_ok & w_bit;
`endif

    always_comb begin
        w_and = '1;
        w_or  = '0;
        for (int i = 0; i < population; i++) begin
            w_and = w_and & r_fitness[i];
            w_or  = w_or  | r_fitness[i];
        end
    end

    assign rank_index = (rank_addr < POP8) ? r_bank[r_bank_sel][rank_addr[IDX_W-1:0]] : '0;
    assign andAll     = r_and_all;
    assign orAll      = r_or_all;
    assign sort_done  = r_sort_done;
    assign load_err   = r_load_err;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            // NOTE: fitness and bank arrays are reset explicitly; a reset mid-sort must leave identity ranks and zero fitness.
            for (int i = 0; i < population; i++) begin
                r_fitness[i] <= '0;
                r_bank[0][i] <= idx_t'(i);
                r_bank[1][i] <= idx_t'(i);
            end
            r_bank_sel  <= 1'b0;
            r_dirty     <= 1'b0;
            r_sort_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_and_all   <= '0;
            r_or_all    <= '0;
        end else begin
            r_and_all   <= w_and;
            r_or_all    <= w_or;
            r_sort_done <= w_sorting && (state_sortFSM == SFSM_DONE);
            if (w_sorting) begin
                case (state_sortFSM)
                    SFSM_INIT: begin
                        for (int i = 0; i < population; i++) begin
                            r_bank[0][i] <= idx_t'(i);
                            r_bank[1][i] <= idx_t'(i);
                        end
                        r_bank_sel <= 1'b0;
                        r_dirty    <= 1'b0;
                    end
                    SFSM_PLACE0, SFSM_PLACE1: begin
                        if (w_src_ok && w_dst_ok) begin
                            r_bank[~r_bank_sel][w_dst_pos] <= w_src_gene;
                        end
                        r_dirty <= 1'b1;
                    end
                    SFSM_ADVANCE: begin
                        // A skipped (uniform) bit placed nothing, so the source ordering stays put.
                        if (r_dirty) begin
                            r_bank_sel <= ~r_bank_sel;
                        end
                        r_dirty <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (load_we) begin
                if (load_index < POP8) begin
                    r_fitness[load_index[IDX_W-1:0]] <= load_fitness;
                end else begin
                    r_load_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_data_server.sv
// Self-checking bench for sort_data_server: the bench plays the radix sorter and compares against a stable-sort model.
// Build with SORT_DESCENDING_EN defined to check the descending variant.
`timescale 1ns/1ps
module tb_sort_data_server;
    localparam int         PIC  = 2;
    localparam int         P    = 4;
    localparam int         W    = PIC + 2;
    localparam logic [2:0] SORT = 3'b001;

    typedef int perm_t [P];

    logic         CLOCK_50 = 1'b0;
    logic         reset;
    logic [2:0]   state_controller;
    logic [3:0]   state_sortFSM;
    logic [7:0]   sortGeneCount;
    logic [7:0]   sortBitCount;
    logic [7:0]   sortedCounter;
    logic         load_we;
    logic [7:0]   load_index;
    logic [W-1:0] load_fitness;
    logic         gene;
    logic [W-1:0] andAll;
    logic [W-1:0] orAll;
    logic [7:0]   rank_addr;
    logic [7:0]   rank_index;
    logic         sort_done;
    logic         load_err;

    always #5 CLOCK_50 = ~CLOCK_50;

    sort_data_server #(
        .primaryInputCount(PIC),
        .population       (P),
        .sort_controller  (SORT)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .state_controller(state_controller),
        .state_sortFSM   (state_sortFSM),
        .sortGeneCount   (sortGeneCount),
        .sortBitCount    (sortBitCount),
        .sortedCounter   (sortedCounter),
        .load_we         (load_we),
        .load_index      (load_index),
        .load_fitness    (load_fitness),
        .gene            (gene),
        .andAll          (andAll),
        .orAll           (orAll),
        .rank_addr       (rank_addr),
        .rank_index      (rank_index),
        .sort_done       (sort_done),
        .load_err        (load_err)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int    m_fit [P];
    perm_t m_perm;
    int    m_and, m_or;
    bit    m_err, m_done, m_dirty;

    function automatic int key(input int v);
`ifdef SORT_DESCENDING_EN
        return (~v) & ((1 << W) - 1);
`else
        return v;
`endif
    endfunction

    // Ordering the sorter must hold after finishing passes over bits 0..nbits-1.
    function automatic perm_t stable_sort(input int nbits);
        perm_t p;
        int    mask = (1 << nbits) - 1;
        foreach (p[i]) p[i] = i;
        for (int i = 1; i < P; i++) begin
            int t, j;
            t = p[i];
            j = i - 1;
            while (j >= 0 && (key(m_fit[p[j]]) & mask) > (key(m_fit[t]) & mask)) begin
                p[j+1] = p[j];
                j--;
            end
            p[j+1] = t;
        end
        return p;
    endfunction

    function automatic int exp_gene();
        if (sortGeneCount < P && sortBitCount < W)
            return (key(m_fit[m_perm[sortGeneCount]]) >> sortBitCount) & 1;
        return 0;
    endfunction

    function automatic int exp_rank();
        return (rank_addr < P) ? m_perm[rank_addr] : 0;
    endfunction

    always @(posedge CLOCK_50) begin
        int a, o;
        if (reset) begin
            foreach (m_fit[i]) begin
                m_fit[i]  = 0;
                m_perm[i] = i;
            end
            m_err = 0; m_and = 0; m_or = 0; m_done = 0; m_dirty = 0;
        end else begin
            a = (1 << W) - 1;
            o = 0;
            foreach (m_fit[i]) begin
                a &= m_fit[i];
                o |= m_fit[i];
            end
            m_and  = a;
            m_or   = o;
            m_done = (state_controller == SORT) && (state_sortFSM == 4'd8);
            if (state_controller == SORT) begin
                if (state_sortFSM == 4'd0) begin
                    foreach (m_perm[i]) m_perm[i] = i;
                    m_dirty = 0;
                end else if (state_sortFSM == 4'd6 || state_sortFSM == 4'd7) begin
                    m_dirty = 1;
                end else if (state_sortFSM == 4'd5) begin
                    if (m_dirty) m_perm = stable_sort(int'(sortBitCount) + 1);
                    m_dirty = 0;
                end
            end else if (load_we) begin
                if (load_index < P) m_fit[load_index] = int'(load_fitness);
                else                m_err = 1;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            check("andAll",     andAll,     m_and);
            check("orAll",      orAll,      m_or);
            check("load_err",   load_err,   m_err);
            check("sort_done",  sort_done,  m_done);
            check("gene",       gene,       exp_gene());
            check("rank_index", rank_index, exp_rank());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        rank_addr = 8'($urandom_range(0, P + 2));
    endtask

    task automatic load(input int idx, input int val);
        load_we      = 1'b1;
        load_index   = 8'(idx);
        load_fitness = W'(val);
        tick();
        load_we = 1'b0;
    endtask

    task automatic load4(input int v0, input int v1, input int v2, input int v3);
        load(0, v0); load(1, v1); load(2, v2); load(3, v3);
    endtask

    // Plays the sorter; abort_after>=0 asserts reset on that placement, bad_load>=0 drives a load during init.
    task automatic run_sort(input int abort_after, input int bad_load);
        int cnt;
        int placed = 0;
        state_controller = SORT;
        state_sortFSM    = 4'd0;
        if (bad_load >= 0) begin
            load_we      = 1'b1;
            load_index   = 8'(bad_load);
            load_fitness = W'($urandom_range(0, (1 << W) - 1));
        end
        tick();
        load_we       = 1'b0;
        state_sortFSM = 4'd1;
        sortGeneCount = 8'(P + 1); sortBitCount = 8'd0; tick();
        sortGeneCount = 8'd0;      sortBitCount = 8'(W); tick();
        for (int b = 0; b < W; b++) begin
            sortBitCount  = 8'(b);
            state_sortFSM = 4'd1;
            if (andAll[b] !== orAll[b]) begin
                cnt = 0;
                for (int ph = 0; ph < 2; ph++) begin
                    for (int g = 0; g < P; g++) begin
                        state_sortFSM = 4'd1;
                        sortGeneCount = 8'(g);
                        tick();
                        if (gene == ph[0]) begin
                            state_sortFSM = (ph == 0) ? 4'd6 : 4'd7;
                            sortedCounter = 8'(cnt);
                            if (abort_after >= 0 && placed == abort_after) reset = 1'b1;
                            tick();
                            cnt++;
                            placed++;
                            if (reset) begin
                                reset            = 1'b0;
                                state_controller = 3'd0;
                                state_sortFSM    = 4'd0;
                                return;
                            end
                        end
                    end
                end
            end
            state_sortFSM = 4'd5;
            tick();
        end
        state_sortFSM = 4'd8;
        tick();
        check("sort_done_set", sort_done, 1);
    endtask

    task automatic leave_sort();
        state_controller = 3'd0;
        state_sortFSM    = 4'd0;
        tick();
        check("sort_done_clear", sort_done, 0);
    endtask

    task automatic check_ranks(input int r0, input int r1, input int r2, input int r3);
        int exp [P];
        exp[0] = r0; exp[1] = r1; exp[2] = r2; exp[3] = r3;
        for (int i = 0; i < P; i++) begin
            tick();
            rank_addr = 8'(i);
            #1;
            check($sformatf("rank%0d", i), rank_index, exp[i]);
        end
    endtask

    initial begin
        reset = 1'b1;
        state_controller = 3'd0; state_sortFSM = 4'd0;
        sortGeneCount = 8'd0; sortBitCount = 8'd0; sortedCounter = 8'd0;
        load_we = 1'b0; load_index = 8'd0; load_fitness = '0; rank_addr = 8'd0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // reset state
        check("reset_andAll", andAll, 0);
        check("reset_orAll", orAll, 0);
        check("reset_load_err", load_err, 0);
        check("reset_sort_done", sort_done, 0);
        check_ranks(0, 1, 2, 3);

        // basic sort, with an out-of-range load attempted during the sort phase
        load4(3, 1, 2, 0);
        run_sort(-1, 9);
        check("basic_andAll", andAll, 0);
        check("basic_orAll", orAll, 3);
        check("load_err_ignored_in_sort", load_err, 0);
`ifdef SORT_DESCENDING_EN
        check_ranks(0, 2, 1, 3);
`else
        check_ranks(3, 1, 2, 0);
`endif
        leave_sort();

        // stability on ties
        load4(2, 1, 2, 1);
        run_sort(-1, -1);
`ifdef SORT_DESCENDING_EN
        check_ranks(0, 2, 1, 3);
`else
        check_ranks(1, 3, 0, 2);
`endif
        leave_sort();

        // uniform population: every bit skipped
        load4(5, 5, 5, 5);
        tick();
        check("uniform_andAll", andAll, 5);
        check("uniform_orAll", orAll, 5);
        run_sort(-1, -1);
        check_ranks(0, 1, 2, 3);
        leave_sort();

        // out-of-range load is sticky; in-sort load leaves it alone
        load(7, 3);
        tick();
        check("load_err_set", load_err, 1);
        run_sort(-1, 2);
        check("load_err_sticky", load_err, 1);
        leave_sort();
        check("load_err_held", load_err, 1);

        // randomized populations
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < P + 2; k++) begin
                if (k < P) load(k, int'($urandom_range(0, (1 << W) - 1)));
                else       load(int'($urandom_range(0, P - 1)), int'($urandom_range(0, (1 << W) - 1)));
            end
            run_sort(-1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, P + 3)) : -1);
            leave_sort();
        end

        // reset mid-sort during a place state
        load4(3, 1, 2, 0);
        run_sort(2, -1);
        check("abort_sort_done", sort_done, 0);
        check("abort_load_err", load_err, 0);
        for (int g = 0; g < P; g++) begin
            tick();
            sortGeneCount = 8'(g);
            sortBitCount  = 8'(g % 2);
            #1;
`ifdef SORT_DESCENDING_EN
            check("abort_gene", gene, 1);
`else
            check("abort_gene", gene, 0);
`endif
        end
        check_ranks(0, 1, 2, 3);
        check("abort_andAll", andAll, 0);
        check("abort_orAll", orAll, 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sort_data_server.md
Name: sort_data_server

Overview:
- Data-side responder for the counting/radix sort state machine in the evolution loop.
- Stores per-gene fitness words and answers the sorter's (gene, bit) bit query combinationally.
- Publishes the population-wide AND/OR of all fitness words so the sorter can skip uniform bits.
- Maintains ping-pong permutation banks that record each pass's placements; downstream selection logic reads the final ranking.

Parameters:
primaryInputCount, 8, fitness word width is primaryInputCount+2 (W)
population, 24, number of genes; valid indices 0..population-1
sort_controller, 3'b001, state_controller value during which sorting runs

Ports:
CLOCK_50  in  1  clock
reset  in  1  synchronous, active-high
state_controller  in  3  top-level phase
state_sortFSM  in  4  sorter state (0 initial, 5 bit advance, 6 place-zero, 7 place-one, 8 finished)
sortGeneCount  in  8  source-position pointer from the sorter
sortBitCount  in  8  current fitness bit
sortedCounter  in  8  destination-position pointer from the sorter
load_we  in  1  fitness write strobe
load_index  in  8  gene index for the write
load_fitness  in  W  fitness value
gene  out  1  fitness[src[sortGeneCount]][sortBitCount]
andAll  out  W  AND of all fitness words
orAll  out  W  OR of all fitness words
rank_addr  in  8  rank to read
rank_index  out  8  gene index holding that rank
sort_done  out  1  sorter in finished state
load_err  out  1  sticky; set on an out-of-range load

Behaviour:
- Reset values:
  - All fitness entries are 0.
  - Both permutation banks are identity (entry i = i).
  - bank_sel=0, dirty=0.
  - andAll=0, orAll=0, sort_done=0, load_err=0.
- Load:
  - Accepted only when state_controller != sort_controller and load_we=1.
  - If load_index < population, fitness[load_index] is written at the edge.
  - If load_index >= population, nothing is written and load_err is set. load_err clears only on reset.
  - load_we while sorting is ignored and does not set load_err.
- AND/OR:
  - andAll and orAll are registered reductions over all population entries, recomputed every cycle.
  - Latency is 1 cycle after the write edge.
- Query:
  - gene is combinational from the registered arrays and the current inputs. No added latency, because the sorter samples it in the cycle after changing its pointers.
  - src = bank[bank_sel].
  - If sortGeneCount >= population or sortBitCount >= W, gene = 0.
- Sort-phase actions apply only when state_controller == sort_controller:
  - state_sortFSM = 0: both banks load identity, bank_sel <= 0, dirty <= 0.
  - state_sortFSM = 6 or 7: dst[sortedCounter] <= src[sortGeneCount], where dst = bank[~bank_sel]; dirty <= 1. The write is suppressed if either pointer >= population.
  - state_sortFSM = 5: if dirty, bank_sel toggles (new ordering becomes the source); dirty <= 0. If not dirty (bit skipped via andAll==orAll), bank_sel is unchanged.
  - state_sortFSM = 8: sort_done = 1 (registered, one cycle after the sorter enters state 8).
- Leaving sort_controller: sort_done clears the next cycle. Banks and bank_sel hold, so the ranking stays readable.
- Ranking read:
  - rank_index = bank[bank_sel][rank_addr], combinational.
  - Returns 0 if rank_addr >= population.
  - Valid whenever sort_done=1 or after leaving the sort phase.
- Ordering: ascending, LSB-first, stable (equal fitness keeps prior relative order).
- Reset mid-sort: all state returns to reset values; fitness contents are lost and must be reloaded.
- Simultaneous load_we and sort phase: the sort phase wins, load is ignored.

Optional Feature:
SORT_DESCENDING_EN:
- Defined: gene output is inverted (~bit), so the final ranking is descending (rank 0 = highest fitness). andAll/orAll and the skip behaviour are unchanged.
- Undefined: ascending order as above.

Test Plan:
- population=4, primaryInputCount=2: load {3,1,2,0} to indices 0..3, run the sorter to finish -> rank_index for ranks 0..3 = 3,1,2,0; sort_done=1; andAll=0, orAll=3.
- Load {2,1,2,1}, sort -> ranks = 1,3,0,2 (stability check on ties).
- Load all 5 (W=4) -> andAll=orAll=5 one cycle after the last write; every bit skipped, bank_sel stays 0, ranks = 0,1,2,3.
- load_index=7 with population=4 -> no array change, load_err=1 and stays 1 until reset; load_we during sort_controller -> ignored, load_err unchanged.
- Assert reset during place states mid-sort -> next cycle ranks identity, gene=0, sort_done=0, all fitness entries 0.
- Compile with SORT_DESCENDING_EN, load {3,1,2,0} -> ranks = 0,2,1,3.
